// File: rtl/wash_sequencer.sv
// wash_sequencer: wash-program FSM stepping an external timer through soak, wash, rinse and spin.
module wash_sequencer #(
   parameter logic [15:0] SOAK_T    = 16'd10,
   parameter logic [15:0] WASH_T    = 16'd20,
   parameter logic [15:0] RINSE_T   = 16'd15,
   parameter logic [15:0] SPIN_T    = 16'd10,
   parameter logic [23:0] DONE_HOLD = 24'd12_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_run,
   input  logic        i_abort,
   input  logic        i_lid,
   input  logic [1:0]  i_mode,
   input  logic [3:0]  i_response,
   output logic        o_start,
   output logic [15:0] o_state,
   output logic [1:0]  o_step,
   output logic        o_tmr_rst_n,
   output logic [3:0]  o_step_led,
   output logic        o_busy,
   output logic        o_done
);
   typedef enum logic [2:0] {IDLE, CLR, RUN, GAP, HOLD, DONE} state_e;
   state_e      state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [23:0] cnt_q, cnt_d;
   logic [3:0]  sync1_q, sync2_q, hist_q;
   logic        done_ev, active;
   logic [15:0] dur;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= 2'd0;
         cnt_q   <= 24'd0;
         sync1_q <= 4'd0;
         sync2_q <= 4'd0;
         hist_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         sync1_q <= i_response;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end
   // Only a rising flag of the step currently running counts as completion.
   assign done_ev = sync2_q[step_q] & ~hist_q[step_q];
   // The counter restarts from zero whenever a state does not explicitly advance it.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = 24'd0;
      if (i_abort && state_q != IDLE) begin
         state_d = IDLE;
         step_d  = 2'd0;
      end else begin
         case (state_q)
            IDLE: if (i_run && !i_lid) begin
               state_d = CLR;
               step_d  = i_mode;
            end
            CLR: if (cnt_q == 24'd1) state_d = RUN;
                 else cnt_d = cnt_q + 24'd1;
            RUN: state_d = done_ev ? (step_q == 2'd3 ? DONE : GAP) : (i_lid ? HOLD : RUN);
            GAP: begin
               state_d = RUN;
               step_d  = step_q + 2'd1;
            end
            HOLD: state_d = i_lid ? HOLD : RUN;
            DONE: if (cnt_q == DONE_HOLD - 24'd1) begin
               state_d = IDLE;
               step_d  = 2'd0;
            end else cnt_d = cnt_q + 24'd1;
            default: state_d = IDLE;
         endcase
      end
   end
   assign active      = state_q == CLR || state_q == RUN || state_q == GAP || state_q == HOLD;
   assign dur         = step_q == 2'd0 ? SOAK_T : step_q == 2'd1 ? WASH_T : step_q == 2'd2 ? RINSE_T : SPIN_T;
   assign o_start     = state_q == RUN;
   assign o_tmr_rst_n = state_q != CLR;
   assign o_step      = active ? step_q : 2'd0;
   assign o_state     = active ? dur : 16'd0;
   assign o_step_led  = active ? 4'b0001 << step_q : 4'd0;
   assign o_busy      = state_q != IDLE;
   assign o_done      = state_q == DONE;
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed and randomized program runs checked against a step-level expectation model.
module tb_wash_sequencer;
   localparam int HOLD = 16;
   logic        clk = 1'b0;
   logic        rst, i_run, i_abort, i_lid;
   logic [1:0]  i_mode;
   logic [3:0]  i_response;
   logic        o_start, o_tmr_rst_n, o_busy, o_done;
   logic [15:0] o_state;
   logic [1:0]  o_step;
   logic [3:0]  o_step_led;
   int checks = 0;
   int errors = 0;
   int dur[4] = '{10, 20, 15, 10};
   always #5 clk = ~clk;
   wash_sequencer #(.DONE_HOLD(24'd16)) dut (
      .clk(clk), .rst(rst), .i_run(i_run), .i_abort(i_abort), .i_lid(i_lid),
      .i_mode(i_mode), .i_response(i_response), .o_start(o_start), .o_state(o_state),
      .o_step(o_step), .o_tmr_rst_n(o_tmr_rst_n), .o_step_led(o_step_led),
      .o_busy(o_busy), .o_done(o_done)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, ".start"}, 32'(o_start), 32'd0);
      chk({tag, ".trst"}, 32'(o_tmr_rst_n), 32'd1);
      chk({tag, ".state"}, 32'(o_state), 32'd0);
      chk({tag, ".step"}, 32'(o_step), 32'd0);
      chk({tag, ".led"}, 32'(o_step_led), 32'd0);
      chk({tag, ".busy"}, 32'(o_busy), 32'd0);
      chk({tag, ".done"}, 32'(o_done), 32'd0);
   endtask
   task automatic chk_run(input string tag, input int s);
      chk({tag, ".start"}, 32'(o_start), 32'd1);
      chk({tag, ".step"}, 32'(o_step), 32'(s));
      chk({tag, ".state"}, 32'(o_state), 32'(dur[s]));
      chk({tag, ".led"}, 32'(o_step_led), 32'd1 << s);
      chk({tag, ".trst"}, 32'(o_tmr_rst_n), 32'd1);
      chk({tag, ".busy"}, 32'(o_busy), 32'd1);
   endtask
   task automatic start_prog(input logic [1:0] mode);
      i_mode = mode;
      i_run  = 1'b1;
      tick(1);
      i_run  = 1'b0;
      i_mode = 2'($urandom);
      chk("clr1.trst", 32'(o_tmr_rst_n), 32'd0);
      chk("clr1.start", 32'(o_start), 32'd0);
      chk("clr1.busy", 32'(o_busy), 32'd1);
      chk("clr1.step", 32'(o_step), 32'(mode));
      tick(1);
      chk("clr2.trst", 32'(o_tmr_rst_n), 32'd0);
      tick(1);
      chk_run("first", int'(mode));
   endtask
   task automatic lid_pause(input int s);
      i_lid = 1'b1;
      tick(1);
      chk("hold.start", 32'(o_start), 32'd0);
      chk("hold.busy", 32'(o_busy), 32'd1);
      tick($urandom_range(1, 4));
      i_lid = 1'b0;
      tick(1);
      chk_run("resume", s);
   endtask
   task automatic wrong_bit(input int s);
      i_response[s+1] = 1'b1;
      tick(4);
      chk_run("wrongbit", s);
      i_response[s+1] = 1'b0;
      tick(3);
   endtask
   task automatic finish_step(input int s, input bit lid_same);
      i_response[s] = 1'b1;
      tick(2);
      chk("pre_ev.start", 32'(o_start), 32'd1);
      if (lid_same) i_lid = 1'b1;
      tick(1);
      i_lid = 1'b0;
      if (s < 3) begin
         chk("gap.start", 32'(o_start), 32'd0);
         chk("gap.busy", 32'(o_busy), 32'd1);
         tick(1);
         chk_run("next", s + 1);
      end else begin
         chk("done.done", 32'(o_done), 32'd1);
         chk("done.start", 32'(o_start), 32'd0);
         chk("done.state", 32'(o_state), 32'd0);
         chk("done.step", 32'(o_step), 32'd0);
         chk("done.led", 32'(o_step_led), 32'd0);
         chk("done.busy", 32'(o_busy), 32'd1);
      end
   endtask
   task automatic run_program(input logic [1:0] mode, input bit force_all);
      start_prog(mode);
      for (int s = int'(mode); s < 4; s++) begin
         tick($urandom_range(0, 3));
         chk_run("step", s);
         if (force_all || $urandom_range(0, 1) == 1) lid_pause(s);
         if (s < 3 && (force_all || $urandom_range(0, 1) == 1)) wrong_bit(s);
         finish_step(s, $urandom_range(0, 3) == 0);
      end
      i_run = 1'b1;
      tick(HOLD - 1);
      chk("hold_end.done", 32'(o_done), 32'd1);
      tick(1);
      i_run = 1'b0;
      chk_idle("after_done");
      i_response = 4'd0;
      tick(3);
      chk_idle("settled");
   endtask
   initial begin
      rst = 1'b1; i_run = 1'b0; i_abort = 1'b0; i_lid = 1'b0; i_mode = 2'd0; i_response = 4'd0;
      tick(2);
      chk_idle("reset");
      rst = 1'b0;
      tick(1);
      chk_idle("post_reset");
      run_program(2'd0, 1'b1);
      run_program(2'd3, 1'b0);
      for (int k = 0; k < 6; k++) run_program(2'($urandom_range(0, 3)), 1'b0);
      start_prog(2'd2);
      tick(2);
      chk_run("abort_pre", 2);
      i_abort = 1'b1;
      tick(1);
      i_abort = 1'b0;
      chk_idle("abort");
      tick(2);
      chk_idle("abort_stay");
      start_prog(2'd1);
      i_abort = 1'b1;
      tick(1);
      i_abort = 1'b0;
      chk_idle("abort2");
      start_prog(2'd3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk_idle("rst_spin");
      i_lid = 1'b1;
      i_run = 1'b1;
      tick(3);
      chk_idle("lid_run");
      i_run = 1'b0;
      i_lid = 1'b0;
      tick(1);
      chk_idle("final");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
